// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
//   Multi-key debouncer for raw, bouncing, active-low push buttons.
//   Each channel has its own logic, and channels never interact. A channel has:
//     - a two-flop synchroniser that brings the asynchronous key level into the clk domain,
//     - a stable-time counter that accepts a level change only after DEBOUNCE_CYCLES
//       consecutive cycles that disagree with the current debounced level,
//     - registered press/release pulses that change on the same edge as key_state.
//   All outputs come straight from flops. A reset clears them and never produces a pulse.

module key_debounce_pulse #(
    parameter int N               = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_state,
    output logic [N-1:0] key_pulse,
    output logic [N-1:0] key_rel_pulse
);

    // The last count value before a commit. The counter never goes past it, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    genvar i;
    generate
        for (i = 0; i < N; i = i + 1) begin : g_ch
            logic             sync1_r;
            logic             sync2_r;
            logic [CNT_W-1:0] cnt_r;
            logic             state_r;
            logic             press_r;
            logic             rel_r;

            logic [CNT_W-1:0] cnt_nxt_s;
            logic             state_nxt_s;
            logic             press_nxt_s;
            logic             rel_nxt_s;
            logic             differs_s;
            logic             at_max_s;

            // Two-flop synchroniser. Idle is 1 (released), so a reset never looks like a press.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_r <= 1'b1;
                    sync2_r <= 1'b1;
                end else begin
                    sync1_r <= key[i];
                    sync2_r <= sync1_r;
                end
            end

            // Next-state logic: count disagreeing cycles, commit at the limit, and restart on any bounce back.
            always_comb begin
                differs_s   = (sync2_r != state_r);
                at_max_s    = (cnt_r == CNT_MAX);
                cnt_nxt_s   = cnt_r;
                state_nxt_s = state_r;
                press_nxt_s = 1'b0;
                rel_nxt_s   = 1'b0;
                if (!differs_s) begin
                    // Input agrees with the debounced level again: any count in progress is abandoned.
                    cnt_nxt_s = CNT_ZERO;
                end else if (!at_max_s) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    // Stable for long enough: take the new level and flag which way it moved.
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = sync2_r;
                    press_nxt_s = ~sync2_r;
                    rel_nxt_s   = sync2_r;
                end
            end

            // Debounce state, counter and pulse registers. The pulses update on the same edge as the level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= 1'b1;
                    press_r <= 1'b0;
                    rel_r   <= 1'b0;
                end else begin
                    cnt_r   <= cnt_nxt_s;
                    state_r <= state_nxt_s;
                    press_r <= press_nxt_s;
                    rel_r   <= rel_nxt_s;
                end
            end

            assign key_state[i]     = state_r;
            assign key_pulse[i]     = press_r;
            assign key_rel_pulse[i] = rel_r;
        end
    endgenerate

endmodule
